// File: rtl/iir_biquad_mac.sv
// rtl/iir_biquad_mac.sv - time-multiplexed biquad IIR, one MAC per clock over n1,n2,n3,d1,d2.
// Define IIR_SAT_EN to clamp the output to the X_W range instead of wrapping.
`timescale 1ns/1ps
module iir_biquad_mac #(
   parameter int X_W    = 16,
   parameter int COEF_W = 32,
   parameter int FRAC   = 16,
   parameter int ACC_W  = 52
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [X_W-1:0]    x_in,
   input  logic                     x_valid,
   input  logic signed [COEF_W-1:0] coef_in,
   output logic                     coef_enable,
   output logic signed [X_W-1:0]    y_out,
   output logic                     y_valid,
   output logic                     busy,
   output logic                     overrun
);

   localparam int P_W = X_W + COEF_W;
   localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC - 1);
   localparam logic signed [ACC_W-1:0] MAXV = (ACC_W'(1) <<< (X_W - 1)) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] MINV = -(ACC_W'(1) <<< (X_W - 1));

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [2:0]              r_idx;
   logic signed [ACC_W-1:0] r_acc;
   logic signed [X_W-1:0]   r_x0, r_x1, r_x2, r_y1, r_y2;
   logic signed [X_W-1:0]   r_y_out;
   logic                    r_y_valid;
   logic                    r_overrun;

   logic signed [X_W-1:0]   w_operand;
   logic signed [P_W-1:0]   w_prod;
   logic signed [ACC_W-1:0] w_prod_ext;
   logic signed [ACC_W-1:0] w_shift;
   logic signed [X_W-1:0]   w_y_new;

   // Operand order must match the ROM rotation n1, n2, n3, d1, d2.
   always_comb begin
      w_operand = r_x0;
      case (r_idx)
         3'd0:    w_operand = r_x0;
         3'd1:    w_operand = r_x1;
         3'd2:    w_operand = r_x2;
         3'd3:    w_operand = r_y1;
         3'd4:    w_operand = r_y2;
         default: w_operand = r_x0;
      endcase
   end

   assign w_prod     = P_W'($signed(coef_in)) * P_W'($signed(w_operand));
   assign w_prod_ext = {{(ACC_W - P_W){w_prod[P_W-1]}}, w_prod};
   assign w_shift    = (r_acc + HALF) >>> FRAC;

`ifdef IIR_SAT_EN
   always_comb begin
      w_y_new = w_shift[X_W-1:0];
      if (w_shift > MAXV)
         w_y_new = MAXV[X_W-1:0];
      else if (w_shift < MINV)
         w_y_new = MINV[X_W-1:0];
   end
`else
   assign w_y_new = w_shift[X_W-1:0];
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (x_valid) w_state_nxt = S_MAC;
         S_MAC:   if (r_idx == 3'd4) w_state_nxt = S_OUT;
         S_OUT:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx     <= 3'd0;
         r_acc     <= '0;
         r_x0      <= '0;
         r_x1      <= '0;
         r_x2      <= '0;
         r_y1      <= '0;
         r_y2      <= '0;
         r_y_out   <= '0;
         r_y_valid <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_y_valid <= 1'b0;
         if (x_valid && (r_state != S_IDLE))
            r_overrun <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (x_valid) begin
                  r_x0  <= x_in;
                  r_acc <= '0;
                  r_idx <= 3'd0;
               end
            end
            S_MAC: begin
               r_acc <= r_acc + w_prod_ext;
               r_idx <= (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
            end
            S_OUT: begin
               r_y_out   <= w_y_new;
               r_y_valid <= 1'b1;
               r_x2      <= r_x1;
               r_x1      <= r_x0;
               r_y2      <= r_y1;
               r_y1      <= w_y_new;
            end
            default: ;
         endcase
      end
   end

   // Decoded from the state register so the ROM steps on the same edge its coefficient is consumed.
   assign coef_enable = (r_state == S_MAC);
   assign busy        = (r_state != S_IDLE);
   assign y_out       = r_y_out;
   assign y_valid     = r_y_valid;
   assign overrun     = r_overrun;

endmodule

// File: doc/iir_biquad_mac.md
Name: iir_biquad_mac

Overview:
- Time-multiplexed second-order IIR engine that consumes the rotating coefficient stream of the filter coefficient ROM stage, which sits directly upstream.
- For each accepted input sample, runs five multiply-accumulate cycles with coefficients in the fixed order n1, n2, n3, d1, d2.
- Drives the ROM's advance-enable so the ROM sits on n1 again when the sample completes.
- Produces one filtered sample per input sample.

Parameters:
- X_W, 16, signed sample width for x_in and y_out.
- COEF_W, 32, signed coefficient width, Q16.16 format.
- FRAC, 16, fractional bits of the coefficients; used for the output shift.
- ACC_W, 52, signed accumulator width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- x_in  in  X_W  signed input sample
- x_valid  in  1  x_in is valid this cycle
- coef_in  in  COEF_W  current coefficient from the ROM output
- coef_enable  out  1  advance the ROM by one coefficient at this edge
- y_out  out  X_W  filtered sample
- y_valid  out  1  one-cycle strobe, y_out is new
- busy  out  1  high while a sample is in progress
- overrun  out  1  sticky flag: an x_valid arrived while busy

Behaviour:
- Reset is asynchronous and active-high, and is decided at the interface level: one clock (clk), reset port named reset. On reset:
  - state becomes IDLE, tap index 0, accumulator 0.
  - The history registers x1, x2, y1, y2 are cleared to 0.
  - y_out = 0, y_valid = 0, overrun = 0, coef_enable = 0, busy = 0.
- Reset must be held together with the ROM's reset so that both start aligned on n1.
- Filter equation: y[n] = n1·x[n] + n2·x[n-1] + n3·x[n-2] + d1·y[n-1] + d2·y[n-2]. The d-coefficients are stored pre-negated, so every term is added.
- State machine IDLE -> MAC -> OUT -> IDLE:
  - IDLE: at edge E0 with x_valid=1, latch x_in into x0, clear the accumulator, set idx=0, go to MAC.
  - MAC (idx 0..4): operand is x0, x1, x2, y1, y2 for idx 0..4. Each edge E1..E5 does acc <= acc + sign_extend(coef_in × operand). coef_enable = 1 throughout MAC (decoded from the state register), so the ROM rotates at the same edge the current coefficient is consumed. At idx=4 go to OUT.
  - OUT: at edge E6:
    - y_out <= saturate(round(acc >>> FRAC)), rounding half-up by adding 2^(FRAC-1) before the shift.
    - y_valid <= 1 for exactly one cycle.
    - History update: x2 <= x1, x1 <= x0, y2 <= y1, y1 <= y_out_new.
    - Go to IDLE.
- Exactly five coef_enable pulses per sample, so the ROM returns to n1.
- Latency: y_valid is high in the cycle after E6, i.e. 6 clocks after the x_valid edge. Maximum throughput is one sample per 7 clocks.
- busy = (state != IDLE).
- x_valid while busy: the sample is dropped, overrun is set to 1 and stays set until reset. In-progress computation is unaffected.
- x_valid in the OUT cycle also counts as busy and is dropped.
- Product width is X_W+COEF_W = 48 bits, sign-extended to ACC_W. Accumulator wrap is not checked; ACC_W provides 4 bits of headroom for the 5 terms.
- Reset mid-sample: everything is cleared immediately, including history. The partial result is discarded, and y_valid is not asserted.

Optional Feature:
- IIR_SAT_EN
  - Defined: the shifted result is clamped to [-2^(X_W-1), 2^(X_W-1)-1], i.e. [-32768, 32767].
  - Undefined: the result is truncated to the low X_W bits (two's-complement wrap), with no saturation logic.

Test Plan:
- Pass-through: bench ROM holds n1=0x00010000, all other coefficients 0. Samples 100, -200, 32767 -> y_out 100, -200, 32767, each 6 clocks after its x_valid. Exactly 5 coef_enable pulses per sample.
- Recursive decay: n1=0x00010000, d1=0x00008000 (0.5), others 0. Impulse 1000 then zeros -> y_out 1000, 500, 250, 125, 63 (round half-up), 32.
- FIR taps: n1=n2=n3=0x00010000, d=0. Step of 10 -> y_out 10, 20, 30, 30.
- Saturation: n1=0x00040000 (4.0), x=20000 -> y_out 32767 with IIR_SAT_EN. Without it -> low 16 bits of 80000 = 14464.
- Overrun: assert x_valid on two consecutive cycles -> the first sample is processed, the second is dropped, overrun=1 stays high, and the ROM is still aligned on n1 (next result correct).
- Reset mid-MAC: reset asserted at idx=2 -> outputs and history are 0 asynchronously, no y_valid. After ROM and block are both released, a fresh impulse reproduces the decay sequence.
